// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage: PC register, synchronous-read imem requests,
// one-entry skid buffer for decode back-pressure, and redirect flush.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        misalign,
   output logic [31:0] fetch_count
);

   logic [31:0] fetch_pc;
   logic        inflight_valid;
   logic [31:0] inflight_pc;
   logic        skid_valid;
   logic [31:0] skid_pc;
   logic [31:0] skid_instr;
   logic        load_en;

   always_comb begin
      imem_en   = !rst && !stall && !redirect_valid;
      imem_addr = fetch_pc;
      load_en   = !stall || !if_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc       <= RESET_PC;
         inflight_valid <= 1'b0;
         inflight_pc    <= '0;
         skid_valid     <= 1'b0;
         skid_pc        <= '0;
         skid_instr     <= '0;
         if_valid       <= 1'b0;
         if_pc          <= '0;
         if_instr       <= '0;
         misalign       <= 1'b0;
         fetch_count    <= '0;
      end else if (redirect_valid) begin
         // Redirect flushes everything in flight, including a held skid word.
         fetch_pc       <= {redirect_pc[31:2], 2'b00};
         misalign       <= |redirect_pc[1:0];
         inflight_valid <= 1'b0;
         skid_valid     <= 1'b0;
         if_valid       <= 1'b0;
      end else begin
         misalign       <= 1'b0;
         inflight_valid <= imem_en;
         if (imem_en) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
         end

         if (load_en) begin
            if (skid_valid) begin
               if_valid    <= 1'b1;
               if_pc       <= skid_pc;
               if_instr    <= skid_instr;
               skid_valid  <= 1'b0;
               fetch_count <= fetch_count + 32'd1;
            end else if (inflight_valid) begin
               if_valid    <= 1'b1;
               if_pc       <= inflight_pc;
               if_instr    <= imem_rdata;
               fetch_count <= fetch_count + 32'd1;
            end else begin
               if_valid <= 1'b0;
            end
         end else if (inflight_valid) begin
            // Memory data is not held past its cycle, so park it while decode stalls.
            skid_valid <= 1'b1;
            skid_pc    <= inflight_pc;
            skid_instr <= imem_rdata;
         end
      end
   end

endmodule
